// File: rtl/seg7_scan_pio.sv
// seg7_scan_pio: Avalon-MM slave driving a multiplexed, active-low 7-segment
// display. Four word registers: DIGITS, CONTROL, BLINK_DIV and STATUS.
// Optional blink support is compiled in when SEG7_SCAN_PIO_BLINK_EN is defined.
module seg7_scan_pio #(
  parameter int          NUM_DIGITS  = 6,
  parameter int          SCAN_DIV    = 1000,
  parameter logic [31:0] BLINK_RESET = 32'd25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] dig_sel_n
);

  localparam logic [31:0] DIG_MASK   = (NUM_DIGITS >= 8) ? 32'hFFFF_FFFF
                                       : ((32'd1 << (4 * NUM_DIGITS)) - 32'd1);
  localparam logic [7:0]  SLOT_MASK  = (NUM_DIGITS >= 8) ? 8'hFF
                                       : 8'((16'd1 << NUM_DIGITS) - 16'd1);
  localparam logic [31:0] PRESC_LAST = 32'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic        wr;
  logic [31:0] digits;
  logic        enable;
  logic [7:0]  dp_mask;
  logic [31:0] presc;
  logic [2:0]  idx;
  logic [7:0]  blink_mask;
  logic [31:0] blink_div;
  logic        phase;

  assign wr = chipselect & ~write_n;

  // Host-writable DIGITS and CONTROL fields; unimplemented bits stay zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits  <= '0;
      enable  <= 1'b0;
      dp_mask <= '0;
    end else if (wr) begin
      case (address)
        2'd0: digits <= writedata & DIG_MASK;
        2'd1: begin
          enable  <= writedata[0];
          dp_mask <= writedata[15:8] & SLOT_MASK;
        end
        default: ;
      endcase
    end
  end

  // Slot prescaler and digit index; free-running regardless of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + 32'd1;
    end
  end

`ifdef SEG7_SCAN_PIO_BLINK_EN
  logic [31:0] blink_cnt;

  // Blink mask, half-period register and phase generator; a divider write restarts the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_mask <= '0;
      blink_div  <= BLINK_RESET;
      blink_cnt  <= '0;
      phase      <= 1'b0;
    end else begin
      if (wr && address == 2'd1) blink_mask <= writedata[23:16] & SLOT_MASK;
      if (wr && address == 2'd2) begin
        blink_div <= writedata;
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_div == '0) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == blink_div - 32'd1) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end
    end
  end
`else
  // No blink hardware in this build; BLINK_RESET is kept only for port/parameter compatibility.
  assign blink_mask = '0;
  assign blink_div  = BLINK_RESET & 32'h0;
  assign phase      = 1'b0;
`endif

  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic                  blank;
  logic [NUM_DIGITS-1:0] sel;

  // Hex decode of the current digit and blank/select qualification.
  always_comb begin
    nibble = digits[{idx, 2'b00} +: 4];
    blank  = blink_mask[idx] & phase;
    sel    = ~(NUM_DIGITS'(1) << idx);
    case (nibble)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      default: seg_dec = 7'h0E;
    endcase
  end

  // Registered display drive, one cycle behind the register/index state.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      seg_n     <= 7'h7F;
      dp_n      <= 1'b1;
      dig_sel_n <= '1;
    end else begin
      seg_n     <= blank ? 7'h7F : seg_dec;
      dp_n      <= blank | ~dp_mask[idx];
      dig_sel_n <= sel;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = digits;
      2'd1: readdata = {8'h00, blink_mask, dp_mask, 7'h00, enable};
      2'd2: readdata = blink_div;
      default: readdata = {23'h0, phase, 5'h00, idx};
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_pio.sv
// Testbench for seg7_scan_pio (NUM_DIGITS=6, SCAN_DIV=4, BLINK_RESET=8).
// Adapts to SEG7_SCAN_PIO_BLINK_EN being defined or not.
module tb_seg7_scan_pio;
  localparam int          ND = 6;
  localparam int          SD = 4;
  localparam logic [31:0] BR = 32'd8;
`ifdef SEG7_SCAN_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [ND-1:0] dig_sel_n;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_scan_pio #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_RESET(BR)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_n(seg_n), .dp_n(dp_n), .dig_sel_n(dig_sel_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of the register file, scanner and blinker.
  typedef struct {logic [6:0] seg; logic dp; logic [ND-1:0] dig;} exp_t;
  exp_t sbq[$];

  bit          m_valid = 1'b0;
  logic [31:0] m_digits, m_bdiv, m_bcnt;
  logic        m_en, m_phase;
  logic [ND-1:0] m_dp, m_bm;
  int          m_presc, m_idx;

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return m_digits;
      2'd1: return {8'h00, BLINK ? {2'b00, m_bm} : 8'h00, 2'b00, m_dp, 7'h00, m_en};
      2'd2: return BLINK ? m_bdiv : 32'h0;
      default: return {23'h0, BLINK & m_phase, 5'h00, 3'(m_idx)};
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic w, bl;
    w = chipselect && !write_n;
    e = '{seg: 7'h7F, dp: 1'b1, dig: '1};
    if (reset) begin
      m_digits = '0; m_en = 1'b0; m_dp = '0; m_bm = '0; m_bdiv = BR;
      m_bcnt = '0; m_phase = 1'b0; m_presc = 0; m_idx = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_en) begin
        bl    = BLINK && m_bm[m_idx] && m_phase;
        e.dig = {ND{1'b1}} ^ (ND'(1) << m_idx);
        e.seg = bl ? 7'h7F : hexseg(m_digits[4*m_idx +: 4]);
        e.dp  = bl || !m_dp[m_idx];
      end
      m_presc++;
      if (m_presc == SD) begin m_presc = 0; m_idx = (m_idx + 1) % ND; end
      if (BLINK) begin
        if (w && address == 2'd2) begin
          m_bdiv = writedata; m_bcnt = '0; m_phase = 1'b0;
        end else if (m_bdiv != 0) begin
          m_bcnt++;
          if (m_bcnt == m_bdiv) begin m_bcnt = '0; m_phase = !m_phase; end
        end
      end
      if (w && address == 2'd0) m_digits = writedata & 32'h00FF_FFFF;
      if (w && address == 2'd1) begin
        m_en = writedata[0];
        m_dp = writedata[8 +: ND];
        if (BLINK) m_bm = writedata[16 +: ND];
      end
    end
    if (m_valid) sbq.push_back(e);
  end

  // Scoreboard consumer, sampling just before each rising edge.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("seg_n", 32'(seg_n), 32'(e.seg));
      check("dp_n", 32'(dp_n), 32'(e.dp));
      check("dig_sel_n", 32'(dig_sel_n), 32'(e.dig));
      check("readdata", readdata, model_rd(address));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    int cnt [ND];
    int toggles, g;
    logic prev;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    address = 2'd2; #1;
    check("rst_blink_div", readdata, BLINK ? 32'd8 : 32'd0);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dig", 32'(dig_sel_n), 32'h3F);

    wr(2'd0, 32'hFF54_3210);
    address = 2'd0; #1;
    check("digits_rd", readdata, 32'h0054_3210);
    wr(2'd1, 32'h1);
    foreach (cnt[k]) cnt[k] = 0;
    repeat (24) begin
      @(negedge clk); #1;
      for (int k = 0; k < ND; k++)
        if (dig_sel_n == ({ND{1'b1}} ^ (ND'(1) << k))) cnt[k]++;
    end
    for (int k = 0; k < ND; k++) check($sformatf("slot_len%0d", k), 32'(cnt[k]), 32'd4);

    wr(2'd1, 32'h0000_0501);
    repeat (24) @(negedge clk);

    wr(2'd1, 32'h0002_0001);
    wr(2'd2, 32'd8);
    address = 2'd3; #1;
    prev = readdata[8];
    toggles = 0;
    repeat (64) begin
      @(negedge clk); #1;
      if (readdata[8] !== prev) toggles++;
      prev = readdata[8];
    end
    check("phase_toggles", 32'(toggles), BLINK ? 32'd8 : 32'd0);

    wr(2'd2, 32'd0);
    repeat (16) @(negedge clk);
    wr(2'd2, 32'd3);
    repeat (20) @(negedge clk);

    address = 2'd3;
    g = 0;
    @(negedge clk); #1;
    while (readdata[2:0] != 3'd3 && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    check("idx3_wait", 32'(g < 100), 32'd1);
    reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h1;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd3; #1;
    check("rst_mid_status", readdata, 32'h0);
    address = 2'd1; #1;
    check("rst_mid_ctrl", readdata, 32'h0);
    address = 2'd0; #1;
    check("rst_mid_digits", readdata, 32'h0);
    repeat (10) @(negedge clk);

    wr(2'd0, 32'h00AB_CDEF);
    wr(2'd1, 32'h00FF_0001);
    address = 2'd1; #1;
    check("ctrl_rd_masked", readdata, BLINK ? 32'h003F_0001 : 32'h0000_0001);
    repeat (48) @(negedge clk);

    repeat (20) begin
      wr(2'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    wr(2'd1, 32'h0000_3F01);
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
